// File: rtl/pc_pkg.sv
// Shared defaults and helpers for the multi-thread fetch program counter.
// Optional build macro: PC_MISALIGN_TRAP_EN (see pc_multithread).
package pc_pkg;
    localparam int          XLEN_DEF         = 32;
    localparam int          NUM_THREADS_DEF  = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int          INC_DEF          = 4;

    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TIDW_DEF = tid_width(NUM_THREADS_DEF);
    typedef logic [TIDW_DEF-1:0] tid_t;

    // Number of low PC bits that must be zero for an aligned fetch address.
    localparam int INC_LSB = $clog2(INC_DEF);
endpackage

// File: rtl/pc_rr_select.sv
// Round-robin pick: first set bit of mask at or after ptr, wrapping past the top thread.
module pc_rr_select #(
    parameter int NUM_THREADS = 4,
    parameter int TIDW        = 2
) (
    input  logic [NUM_THREADS-1:0] mask,
    input  logic [TIDW-1:0]        ptr,
    output logic [TIDW-1:0]        sel,
    output logic                   any
);
    logic [2*NUM_THREADS-1:0] rotated;
    int                       offset;
    int                       pick;

    // Doubling the mask turns the wrap-around scan into a plain low-to-high search.
    assign rotated = {mask, mask} >> ptr;

    always_comb begin
        offset = 0;
        pick   = 0;
        any    = |mask;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (rotated[i]) offset = i;
        end
        pick = int'(ptr) + offset;
        if (pick >= NUM_THREADS) pick = pick - NUM_THREADS;
        sel = TIDW'(pick);
    end
endmodule

// File: rtl/pc_multithread.sv
// Per-thread program counters with round-robin fetch presentation and redirect.
// Define PC_MISALIGN_TRAP_EN to reject misaligned redirects and pulse misalign_err.
module pc_multithread
    import pc_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter int               NUM_THREADS  = NUM_THREADS_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int               INC          = INC_DEF,
    localparam int              TIDW         = tid_width(NUM_THREADS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   PCWrite,
    input  logic [NUM_THREADS-1:0] thread_en,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [TIDW-1:0]        fetch_tid,
    output logic [XLEN-1:0]        fetch_pc,
    input  logic                   redirect_valid,
    input  logic [TIDW-1:0]        redirect_tid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   misalign_err
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0] pc [NUM_THREADS];
    logic [TIDW-1:0] ptr;
    logic [TIDW-1:0] ptr_next;
    logic [TIDW-1:0] sel;
    logic            any;
    logic            fire;
    logic            redir_hit;
    logic            misaligned;
    logic            redir_apply;
    logic [XLEN-1:0] redir_value;

    pc_rr_select #(
        .NUM_THREADS (NUM_THREADS),
        .TIDW        (TIDW)
    ) u_rr_select (
        .mask (thread_en),
        .ptr  (ptr),
        .sel  (sel),
        .any  (any)
    );

    assign fetch_valid = PCWrite & any & ~Reset;
    assign fire        = fetch_valid & fetch_ready;
    assign fetch_tid   = sel;
    assign fetch_pc    = pc[sel];

    assign redir_hit   = redirect_valid && (int'(redirect_tid) < NUM_THREADS);
    assign misaligned  = |(redirect_pc & ALIGN_MASK);
    assign redir_value = redirect_pc & ~ALIGN_MASK;
    assign ptr_next    = (sel == TIDW'(NUM_THREADS - 1)) ? '0 : sel + 1'b1;

`ifdef PC_MISALIGN_TRAP_EN
    logic err_q;

    assign redir_apply  = redir_hit & ~misaligned;
    assign misalign_err = err_q;

    always_ff @(posedge Clk) begin
        if (Reset) err_q <= 1'b0;
        else       err_q <= redir_hit & misaligned;
    end
`else
    assign redir_apply  = redir_hit;
    assign misalign_err = 1'b0;
`endif

    // A redirect to the thread being fired overrides that thread's increment.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_VECTOR;
            ptr <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redir_apply && int'(redirect_tid) == t)
                    pc[t] <= redir_value;
                else if (fire && int'(sel) == t)
                    pc[t] <= pc[t] + XLEN'(INC);
            end
            if (fire) ptr <= ptr_next;
        end
    end
endmodule
